// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus per-bit stability counter, with registered edge pulses
module sw_debounce #(
  parameter int WIDTH = 10,
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W = $clog2(STABLE_CYCLES)
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic [WIDTH-1:0] sync1, sync2, pending, accept;
  logic [CNT_W-1:0] cnt [WIDTH];
  assign pending = sync2 ^ sw_clean;
  // a bit is accepted once it has been pending for the full count
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) accept[i] = pending[i] && (cnt[i] == LAST);
  end
  // two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end
  // per-bit stability counters; any return to the accepted level restarts the count
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= (pending[i] && !accept[i]) ? cnt[i] + 1'b1 : '0;
    end
  end
  // clean level and one-cycle pulses all register on the accept edge
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_clean   <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_clean   <= sw_clean ^ accept;
      sw_rise    <= accept & sync2;
      sw_fall    <= accept & ~sync2;
      sw_changed <= |accept;
    end
  end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed scenarios against a window-based reference model
module tb_sw_debounce;
  localparam int W = 10;
  localparam int S = 4;
  logic CLOCK_50, RESET_N;
  logic [W-1:0] sw_raw, sw_clean, sw_rise, sw_fall;
  logic sw_changed;
  int n_chk = 0, n_pass = 0;
  bit en = 0;

  sw_debounce #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .sw_raw(sw_raw),
    .sw_clean(sw_clean), .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_changed(sw_changed)
  );

  initial CLOCK_50 = 0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // reference: a bit flips when the last S synchronised samples all differ from the clean level
  logic [W-1:0] m_d1, m_d2, m_clean, m_rise, m_fall, pre, diff;
  logic [W-1:0] hist [S];
  logic m_chg;
  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      m_d1 = '0; m_d2 = '0; m_clean = '0; m_rise = '0; m_fall = '0; m_chg = 0;
      for (int j = 0; j < S; j++) hist[j] = '0;
    end else begin
      pre = m_d2;
      m_d2 = m_d1;
      m_d1 = sw_raw;
      for (int j = S - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = pre;
      diff = '1;
      for (int j = 0; j < S; j++) diff = diff & (hist[j] ^ m_clean);
      m_rise = diff & pre;
      m_fall = diff & ~pre;
      m_chg = |diff;
      m_clean = m_clean ^ diff;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge CLOCK_50) if (en)
    chk("model", {sw_clean, sw_rise, sw_fall, sw_changed}, {m_clean, m_rise, m_fall, m_chg});

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    logic [4:0] bounce;
    bounce = 5'b10101;
    RESET_N = 0;
    sw_raw = 10'h3FF;
    en = 1;
    repeat (3) tick();
    chk("reset_outs", {sw_clean, sw_rise, sw_fall, sw_changed}, 0);
    RESET_N = 1;
    repeat (5) tick();
    chk("rst_exit_pre", sw_clean, 0);
    tick();
    chk("rst_exit_clean", sw_clean, 10'h3FF);
    chk("rst_exit_rise", sw_rise, 10'h3FF);
    chk("rst_exit_chg", sw_changed, 1);
    tick();
    chk("rst_exit_rise_end", {sw_rise, sw_changed}, 0);
    sw_raw = 0;
    repeat (6) tick();
    chk("all_fall", sw_fall, 10'h3FF);
    chk("all_fall_clean", sw_clean, 0);
    repeat (2) tick();
    sw_raw = 10'h001;
    repeat (5) tick();
    chk("step_pre", sw_clean, 0);
    tick();
    chk("step_clean", sw_clean, 10'h001);
    chk("step_rise", sw_rise, 10'h001);
    chk("step_fall", sw_fall, 0);
    tick();
    chk("step_rise_end", sw_rise, 0);
    sw_raw = 0;
    repeat (8) tick();
    for (int b = 0; b < 5; b++) begin
      sw_raw = {6'b0, bounce[b], 3'b0};
      tick();
      chk("bounce_quiet", sw_changed, 0);
    end
    repeat (4) tick();
    chk("bounce_pre", sw_clean, 0);
    tick();
    chk("bounce_clean", sw_clean, 10'h008);
    chk("bounce_rise", sw_rise, 10'h008);
    sw_raw = 0;
    repeat (8) tick();
    sw_raw = 10'h020;
    repeat (3) tick();
    sw_raw = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("glitch_quiet", {sw_clean, sw_changed}, 0);
    end
    sw_raw = 10'h201;
    repeat (6) tick();
    chk("simul_rise", sw_rise, 10'h201);
    chk("simul_chg", sw_changed, 1);
    tick();
    chk("simul_chg_end", sw_changed, 0);
    sw_raw = 0;
    repeat (6) tick();
    chk("simul_fall", sw_fall, 10'h201);
    repeat (2) tick();
    sw_raw = 10'h200;
    repeat (8) tick();
    chk("pre_mid_clean", sw_clean, 10'h200);
    sw_raw = 10'h210;
    repeat (2) tick();
    RESET_N = 0;
    #1;
    chk("mid_rst_clean", sw_clean, 0);
    chk("mid_rst_pulse", {sw_rise, sw_fall, sw_changed}, 0);
    repeat (2) tick();
    RESET_N = 1;
    repeat (5) tick();
    chk("mid_rst_pre", sw_clean, 0);
    tick();
    chk("mid_rst_clean2", sw_clean, 10'h210);
    chk("mid_rst_rise", sw_rise, 10'h210);
    tick();
    en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
